// File: rtl/simon_input_arbiter.sv
// simon_input_arbiter: captures the player's button press during the input
// phase, enforces release-before-arm, and declares a timeout when no press
// arrives within TIMEOUT_TICKS tick pulses.
module simon_input_arbiter #(
  parameter int TIMEOUT_TICKS = 3000,
  parameter int TW            = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic [3:0] pressed,
  input  logic [3:0] held,
  input  logic       ack,
  output logic       valid,
  output logic [1:0] color,
  output logic       multi,
  output logic       timeout,
  output logic       busy
);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RELEASE, ARMED, REPORT} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          valid_reg, valid_next;
  logic [1:0]    color_reg, color_next;
  logic          multi_reg, multi_next;
  logic          timeout_reg, timeout_next;
  logic          busy_reg, busy_next;

  logic [1:0]    low_idx;
  logic          multi_hit;

  // Lowest set pressed bit wins; multi flags more than one bit set.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pressed[i]) low_idx = 2'(i);
    end
    multi_hit = (pressed & (pressed - 4'd1)) != 4'b0000;
  end

  // Next-state and next-output logic; enable low overrides everything.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    valid_next   = valid_reg;
    color_next   = color_reg;
    multi_next   = multi_reg;
    timeout_next = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: state_next = RELEASE;
        RELEASE: begin
          // Wait for every button to be let go so a stale hold is never reported.
          if (held == 4'b0000) begin
            state_next = ARMED;
            timer_next = TIMER_LOAD;
          end
        end
        ARMED: begin
          // A press beats a coincident timeout.
          if (pressed != 4'b0000) begin
            state_next = REPORT;
            valid_next = 1'b1;
            color_next = low_idx;
            multi_next = multi_hit;
          end else if (tick) begin
            if (timer_reg == '0) begin
              timeout_next = 1'b1;
              state_next   = IDLE;
            end else begin
              timer_next = timer_reg - 1'b1;
            end
          end
        end
        REPORT: begin
          if (ack) begin
            valid_next = 1'b0;
            state_next = RELEASE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  // State and registered outputs, asynchronously cleared by reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      timer_reg   <= TIMER_LOAD;
      valid_reg   <= 1'b0;
      color_reg   <= 2'b00;
      multi_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      valid_reg   <= valid_next;
      color_reg   <= color_next;
      multi_reg   <= multi_next;
      timeout_reg <= timeout_next;
      busy_reg    <= busy_next;
    end
  end

  assign valid   = valid_reg;
  assign color   = color_reg;
  assign multi   = multi_reg;
  assign timeout = timeout_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_simon_input_arbiter.sv
// Directed testbench for simon_input_arbiter with TIMEOUT_TICKS=3.
module tb_simon_input_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       enable;
  logic [3:0] pressed;
  logic [3:0] held;
  logic       ack;
  logic       valid;
  logic [1:0] color;
  logic       multi;
  logic       timeout;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  simon_input_arbiter #(.TIMEOUT_TICKS(3), .TW(12)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .pressed(pressed), .held(held), .ack(ack),
    .valid(valid), .color(color), .multi(multi),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs set before this are sampled at the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; enable = 1'b0;
    pressed = 4'b0; held = 4'b0; ack = 1'b0;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single press, color 2
    enable = 1'b1;
    step();
    chk("rel_busy", 32'(busy), 32'd1);
    step();  // ARMED
    chk("armed_valid", 32'(valid), 32'd0);
    pressed = 4'b0100;
    step();
    chk("p2_valid", 32'(valid), 32'd1);
    chk("p2_color", 32'(color), 32'd2);
    chk("p2_multi", 32'(multi), 32'd0);
    pressed = 4'b0001;
    step();
    chk("rep_ignore_color", 32'(color), 32'd2);
    chk("rep_hold_valid", 32'(valid), 32'd1);
    pressed = 4'b0000; ack = 1'b1;
    step();
    chk("ack_valid", 32'(valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd1);
    ack = 1'b0;
    step();  // ARMED

    // Multi press, then held blocks re-arm
    pressed = 4'b1010;
    step();
    chk("m_valid", 32'(valid), 32'd1);
    chk("m_color", 32'(color), 32'd1);
    chk("m_multi", 32'(multi), 32'd1);
    pressed = 4'b0000; held = 4'b1000; ack = 1'b1;
    step();
    chk("m_ack_valid", 32'(valid), 32'd0);
    ack = 1'b0; pressed = 4'b0001;
    step();
    chk("held_block1", 32'(valid), 32'd0);
    pressed = 4'b0000;
    step();
    chk("held_block2", 32'(valid), 32'd0);
    held = 4'b0000;
    step();  // ARMED
    held = 4'b0100; pressed = 4'b0001;
    step();
    chk("held_other_valid", 32'(valid), 32'd1);
    chk("held_other_color", 32'(color), 32'd0);
    chk("held_other_multi", 32'(multi), 32'd0);
    pressed = 4'b0000; held = 4'b0000; ack = 1'b1;
    step();  // RELEASE
    ack = 1'b0;
    step();  // ARMED, timer=2

    // Timeout after three ticks
    tick = 1'b1; step();
    chk("to_t1", 32'(timeout), 32'd0);
    tick = 1'b0; step(); step();
    chk("to_notick", 32'(timeout), 32'd0);
    tick = 1'b1; step();
    chk("to_t2", 32'(timeout), 32'd0);
    tick = 1'b0; step();
    chk("to_zero_notick", 32'(timeout), 32'd0);
    tick = 1'b1; step();
    chk("to_t3_timeout", 32'(timeout), 32'd1);
    chk("to_t3_busy", 32'(busy), 32'd0);
    tick = 1'b0; step();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_rel_busy", 32'(busy), 32'd1);
    step();  // ARMED

    // Press coincident with the third tick
    tick = 1'b1; step(); step();
    pressed = 4'b0001; step();
    chk("race_valid", 32'(valid), 32'd1);
    chk("race_color", 32'(color), 32'd0);
    chk("race_timeout", 32'(timeout), 32'd0);
    tick = 1'b0; pressed = 4'b0000; step();
    chk("race_timeout2", 32'(timeout), 32'd0);

    // enable drop discards pending event
    enable = 1'b0; step();
    chk("dis_valid", 32'(valid), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    ack = 1'b1; step();
    chk("dis_ack_valid", 32'(valid), 32'd0);
    chk("dis_ack_busy", 32'(busy), 32'd0);
    enable = 1'b1; step();
    chk("reen_valid", 32'(valid), 32'd0);
    chk("reen_busy", 32'(busy), 32'd1);
    ack = 1'b0; step();  // ARMED

    // enable low beats a press
    enable = 1'b0; pressed = 4'b0001; step();
    chk("pri_valid", 32'(valid), 32'd0);
    chk("pri_busy", 32'(busy), 32'd0);
    enable = 1'b1; pressed = 4'b0000; step(); step();  // ARMED

    // Asynchronous reset during REPORT
    pressed = 4'b1000; step();
    chk("r3_valid", 32'(valid), 32'd1);
    chk("r3_color", 32'(color), 32'd3);
    pressed = 4'b0000;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_color", 32'(color), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_timeout", 32'(timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_input_arbiter.md
SIMON_INPUT_ARBITER -- requirements
Module: simon_input_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 3000, meaning the number of tick pulses allowed for the player to press before timeout is declared (legal 1..4095).
REQ-002 SHALL have parameter TW, default 12, meaning the timeout counter width; TIMEOUT_TICKS-1 SHALL fit in TW bits.
REQ-003 SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port tick  input  1  one-clk strobe from the shared sample timer (nominal 1 ms), the only time base for the timeout.
REQ-006 SHALL have port enable  input  1  high while the game is in the player-input phase.
REQ-007 SHALL have port pressed  input  4  per-button single-cycle press pulses from the four button debouncers, bit i = colour i.
REQ-008 SHALL have port held  input  4  per-button debounced level from the same debouncers.
REQ-009 SHALL have port ack  input  1  consumer accepts the current event.
REQ-010 SHALL have port valid  output  1  a captured press event is pending.
REQ-011 SHALL have port color  output  2  index of the captured button, stable while valid=1.
REQ-012 SHALL have port multi  output  1  more than one pressed bit was high in the capture cycle, stable while valid=1.
REQ-013 SHALL have port timeout  output  1  one-clk pulse when no press arrived in time.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a state machine with states IDLE, RELEASE, ARMED, REPORT; all outputs registered.
REQ-016 IDLE: enable=1 -> RELEASE next clk; otherwise stay.
REQ-017 RELEASE: held==4'b0000 -> ARMED next clk, loading timer to TIMEOUT_TICKS-1; otherwise stay (no timeout counted; stale or still-held buttons are never reported).
REQ-018 ARMED: timer decrements by 1 on each clk with tick=1; no decrement when tick=0.
REQ-019 ARMED: any pressed bit high -> capture color = index of the lowest set bit, multi = (more than one bit set), go REPORT; valid=1 from the next clk.
REQ-020 ARMED: timer==0 and tick=1 with pressed==0 -> timeout=1 for exactly one clk, go IDLE.
REQ-021 ARMED: press and timeout condition in the same clk -> the press SHALL win; no timeout pulse.
REQ-022 ARMED: pressed bits arriving while held is nonzero on other bits SHALL still be captured normally.
REQ-023 REPORT: valid, color, multi held constant; pressed ignored; timer frozen.
REQ-024 REPORT: ack=1 -> valid=0 from the next clk, go RELEASE; ack while valid=0 SHALL be ignored in all states.
REQ-025 enable=0 in any state SHALL force IDLE next clk with valid=0 and no timeout pulse; a pending event is discarded.
REQ-026 enable=0 takes priority over press, ack, and timeout in the same clk.
REQ-027 Latency: pressed pulse in ARMED at clk N -> valid=1 at clk N+1; ack at clk M -> valid=0 at clk M+1; earliest next capture at clk M+3 (RELEASE and ARMED each at least one clk).
REQ-028 Timer SHALL not wrap: after reaching 0 it never decrements further.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, valid=0, color=2'b00, multi=0, timeout=0, busy=0, timer=TIMEOUT_TICKS-1.
REQ-030 reset deassertion SHALL take effect on the next clk edge; reset during REPORT SHALL discard the event with no timeout pulse.

Verification
REQ-031 enable=1, held=0, pressed=4'b0100 in ARMED -> next clk valid=1, color=2, multi=0; ack -> valid=0 next clk, state RELEASE.
REQ-032 pressed=4'b1010 in one clk -> color=1, multi=1; held=4'b1000 kept high after ack -> stays RELEASE, no new event until held=0.
REQ-033 TIMEOUT_TICKS=3, ARMED, no press, three tick pulses -> timeout=1 for one clk on the third tick clk, busy=0 after.
REQ-034 Third tick and pressed=4'b0001 in the same clk -> valid=1, color=0, timeout never asserted.
REQ-035 valid=1 then enable=0 -> valid=0 and busy=0 next clk; later ack pulse has no effect.
REQ-036 reset=0 mid-REPORT between clk edges -> outputs at reset values immediately, before the next clk edge.
